// File: rtl/encoder_input_conditioner.sv
// Synchroniser + debouncer front end for the rotary-encoder A/B pins and push-button.
// Optional bounce counter on glitch_cnt_o is built when ENCODER_GLITCH_CNT_EN is defined.
module encoder_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       A_raw_i,
  input  logic       B_raw_i,
  input  logic       BTN_raw_i,
  output logic       A_o,
  output logic       B_o,
  output logic       BTN_o,
  output logic       BTN_press_o,
  output logic [7:0] glitch_cnt_o
);

  localparam int NUM_CH = 3;
  localparam int CH_BTN = 2;
  // Channel order is {BTN, B, A}; A and B idle high, the button idles low.
  localparam logic [NUM_CH-1:0] IDLE = 3'b011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] flip;
`ifdef ENCODER_GLITCH_CNT_EN
  logic [NUM_CH-1:0] abort;
`endif

  assign raw = {BTN_raw_i, B_raw_i, A_raw_i};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: presetting the chain to the idle level stops a pin held active
    // during reset from being seen as an edge before the full latency.
    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        sync_q  <= {SYNC_STAGES{IDLE[ch]}};
        cnt_q   <= '0;
        level_q <= IDLE[ch];
      end else begin
        // NOTE: non-blocking throughout so every stage samples pre-edge values.
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
        if (synced == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          level_q <= synced;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign level[ch] = level_q;
    assign flip[ch]  = (synced != level_q) && (cnt_q == CNT_LAST);
`ifdef ENCODER_GLITCH_CNT_EN
    assign abort[ch] = (synced == level_q) && (cnt_q != '0);
`endif
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      BTN_press_o <= 1'b0;
    end else begin
      BTN_press_o <= flip[CH_BTN] && !level[CH_BTN];
    end
  end

  assign A_o   = level[0];
  assign B_o   = level[1];
  assign BTN_o = level[CH_BTN];

`ifdef ENCODER_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      glitch_q <= '0;
    end else if ((|abort) && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt_o = glitch_q;
`else
  assign glitch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Self-checking bench for encoder_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Vectors drive inputs after one edge and compare outputs 1 ns after the next.
module tb_encoder_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB - 1;
`ifdef ENCODER_GLITCH_CNT_EN
  localparam logic [7:0] G1 = 8'd1;
`else
  localparam logic [7:0] G1 = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_raw, b_raw, btn_raw;
  logic       a_out, b_out, btn_out, press;
  logic [7:0] glitch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (2)
  ) dut (
    .clk         (clk),
    .rst_i       (rst),
    .A_raw_i     (a_raw),
    .B_raw_i     (b_raw),
    .BTN_raw_i   (btn_raw),
    .A_o         (a_out),
    .B_o         (b_out),
    .BTN_o       (btn_out),
    .BTN_press_o (press),
    .glitch_cnt_o(glitch)
  );

  typedef struct {
    logic        a;
    logic        b;
    logic        btn;
    logic [11:0] exp;  // {A_o, B_o, BTN_o, BTN_press_o, glitch_cnt_o}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic b, input logic btn,
                     input logic ea, input logic eb, input logic ebtn,
                     input logic ep, input logic [7:0] eg);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.btn = btn;
    v.exp = {ea, eb, ebtn, ep, eg};
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] outs();
    return {a_out, b_out, btn_out, press, glitch};
  endfunction

  function automatic logic out_bit(input int sel);
    case (sel)
      0:       return a_out;
      1:       return b_out;
      default: return btn_out;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from a drive until the chosen output reaches val; the first
  // edge after the drive is the first sampling edge, so a full latency is LAT+1.
  task automatic edges_until(input int sel, input logic val, output int n);
    n = 0;
    while (n < 40 && out_bit(sel) !== val) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          presses;
    logic        same;
    logic [1:0]  lvl;
    int          q_sel[4] = '{0, 1, 0, 1};
    logic        q_val[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Bounce: A low for two sampled cycles only.
    add(0,1,0, 1,1,0,0, 8'd0);
    add(0,1,0, 1,1,0,0, 8'd0);
    add(1,1,0, 1,1,0,0, 8'd0);
    add(1,1,0, 1,1,0,0, 8'd0);
    add(1,1,0, 1,1,0,0, G1);
    add(1,1,0, 1,1,0,0, G1);
    add(1,1,0, 1,1,0,0, G1);
    add(1,1,0, 1,1,0,0, G1);
    // A held low: falls on edge 5, B and BTN untouched.
    add(0,1,0, 1,1,0,0, G1);
    add(0,1,0, 1,1,0,0, G1);
    add(0,1,0, 1,1,0,0, G1);
    add(0,1,0, 1,1,0,0, G1);
    add(0,1,0, 1,1,0,0, G1);
    add(0,1,0, 0,1,0,0, G1);
    add(0,1,0, 0,1,0,0, G1);
    // Button high 10 cycles, low 10: rises edge 5, one press, falls edge 15.
    for (int k = 0; k < 20; k++)
      add(0, 1, (k < 10), 0, 1, (k >= 5 && k < 15), (k == 5), G1);

    // Reset with the button held and A low.
    rst = 1'b1; a_raw = 1'b0; b_raw = 1'b1; btn_raw = 1'b1;
    #2;
    check("reset_outs", outs(), {4'b1100, 8'd0});
    tick();
    tick();
    check("reset_hold", outs(), {4'b1100, 8'd0});
    rst = 1'b0;
    edges_until(2, 1'b1, n);
    check("t1_btn_lat", n, LAT + 1);
    check("t1_press", press, 1'b1);
    check("t1_a_fall", a_out, 1'b0);
    tick();
    check("t1_press_one", press, 1'b0);
    a_raw = 1'b1; btn_raw = 1'b0;
    presses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (press === 1'b1) presses++;
    end
    check("t1_no_release_press", presses, 0);
    check("t1_settle", outs(), {4'b1100, 8'd0});

    foreach (vecs[i]) begin
      a_raw = vecs[i].a; b_raw = vecs[i].b; btn_raw = vecs[i].btn;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // A and B falling together, then a full quadrature cycle.
    a_raw = 1'b1;
    repeat (10) tick();
    check("t5_idle", outs(), {4'b1100, G1});
    a_raw = 1'b0; b_raw = 1'b0;
    n = 0; same = 1'b1;
    while (n < 40 && a_out !== 1'b0) begin
      tick();
      n++;
      if (a_out !== b_out) same = 1'b0;
    end
    check("t5_ab_lat", n, LAT + 1);
    check("t5_ab_same_edge", same, 1'b1);
    a_raw = 1'b1; b_raw = 1'b1;
    repeat (10) tick();
    lvl = 2'b11;
    for (int p = 0; p < 4; p++) begin
      if (q_sel[p] == 0) a_raw = q_val[p]; else b_raw = q_val[p];
      edges_until(q_sel[p], q_val[p], n);
      check($sformatf("t5_quad%0d_lat", p), n, LAT + 1);
      lvl[q_sel[p]] = q_val[p];
      check($sformatf("t5_quad%0d_ab", p), {a_out, b_out}, {lvl[0], lvl[1]});
      repeat (10 - n) tick();
    end

    // Reset truncates an in-flight press; a held button needs full latency again.
    btn_raw = 1'b1;
    edges_until(2, 1'b1, n);
    check("t6_btn_lat", n, LAT + 1);
    check("t6_press_pre", press, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_press_trunc", outs(), {4'b1100, 8'd0});
    tick();
    rst = 1'b0;
    edges_until(2, 1'b1, n);
    check("t6_btn_relat", n, LAT + 1);
    check("t6_press_again", press, 1'b1);
    btn_raw = 1'b0;
    repeat (10) tick();

    // Reset two counts into an A debounce.
    a_raw = 1'b0;
    repeat (4) tick();
    check("t6_a_mid", a_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_a_reset", outs(), {4'b1100, 8'd0});
    tick();
    rst = 1'b0;
    edges_until(0, 1'b0, n);
    check("t6_a_relat", n, LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
